clk_en_gen: RTL
===============

# clk_en_gen

Parametrised clock-enable generator for the transmit/receive datapath. It replaces the derived-clock scheme with one clock and enable strobes only. From the single system clock it produces nested, phase-aligned enable strobes at the system, sample and symbol rates, and exposes the intra-sample and intra-symbol phase counters. A run/hold control and a phase re-synchronisation input let symbol timing be realigned to an external event without a full reset.

## Interface
- SYS_DIV, 2: clk cycles per sys_clk_en strobe (≥1)
- SAM_DIV, 4: sys_clk_en strobes per sam_clk_en strobe (≥1)
- SYM_DIV, 4: sam_clk_en strobes per sym_clk_en strobe (≥1)
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-low reset
- en  input  1  run control; low = hold counters, suppress strobes
- sync  input  1  phase re-synchronisation request (single-cycle or level)
- sys_clk_en  output  1  one-clk strobe every SYS_DIV clk
- sam_clk_en  output  1  one-clk strobe every SYS_DIV·SAM_DIV clk
- sym_clk_en  output  1  one-clk strobe every SYS_DIV·SAM_DIV·SYM_DIV clk
- sam2x_clk_en  output  1  strobe at twice the sample rate (see Configuration)
- sam_phase  output  max(1,$clog2(SAM_DIV))  current sys tick within the sample
- sym_phase  output  max(1,$clog2(SYM_DIV))  current sample within the symbol

## Operation
- Internal counters: sys_cnt mod SYS_DIV, sam_cnt mod SAM_DIV, sym_cnt mod SYM_DIV. sam_phase = sam_cnt and sym_phase = sym_cnt, both registered.
- Terminal flags: tS = (sys_cnt==SYS_DIV-1); tA = tS && (sam_cnt==SAM_DIV-1); tY = tA && (sym_cnt==SYM_DIV-1).
- Priority per edge: reset low > sync high > en low > run.
- reset low: all counters 0, all outputs 0.
- sync high (reset high): all counters load 0, all strobes 0 that cycle. Afterwards, timing is identical to a reset release. en is ignored while sync is high.
- en low: counters hold, all strobes 0. Counting resumes from the held value when en returns high, so no phase is lost.
- run:
  - sys_cnt increments and wraps.
  - sam_cnt increments on tS.
  - sym_cnt increments on tA.
  - Strobes register as sys_clk_en<=tS, sam_clk_en<=tA, sym_clk_en<=tY.
- Nesting guarantee: every sym_clk_en coincides with a sam_clk_en, and every sam_clk_en coincides with a sys_clk_en.
- Any DIV=1: that counter is constant 0 and its terminal flag is always true. With SYS_DIV=1, sys_clk_en is high on every running cycle from the first edge after release.

## Timing
- Edge k is the k-th posedge with reset high and no sync, counted from release/sync (k=1 first).
- All outputs are registered with no combinational path from an input to an output. Reset and sync take effect in the cycle after the sampling edge.
- With en held high:
  - sys_clk_en is high after edges k = n·SYS_DIV.
  - sam_clk_en is high after edges k = n·SYS_DIV·SAM_DIV.
  - sym_clk_en is high after edges k = n·SYS_DIV·SAM_DIV·SYM_DIV (n≥1).
- Each strobe is exactly one clk wide, including when DIV=1 at the next level (e.g. SAM_DIV=1 gives sam_clk_en == sys_clk_en).
- Each en-low cycle delays all subsequent strobes by one clk.
- A sync arriving on the same edge as a terminal count suppresses that strobe.

## Configuration
- Macro CLK_EN_GEN_SAM2X_EN.
- Defined:
  - sam2x_clk_en <= tA || (tS && sam_cnt==SAM_DIV/2-1), giving two evenly spaced strobes per sample.
  - Requires even SAM_DIV ≥2; elaboration fails with $error otherwise.
  - Follows the same en/sync suppression rules as the other strobes.
- Undefined: sam2x_clk_en is tied 0, no extra logic, no SAM_DIV restriction.

## Test plan
- Defaults, en=1, sync=0; release reset at edge 0 → sys_clk_en high after edges 2,4,6…; sam_clk_en after 8,16…; sym_clk_en after 32,64…; each exactly 1 clk wide.
- Defaults, after release → sam_phase sequence 0,0,1,1,2,2,3,3,0…; sym_phase steps 0→1 after edge 8 and wraps 3→0 after edge 32.
- en low for 3 clk starting after edge 5 → next sam_clk_en after edge 11 instead of 8; phases frozen during the hold.
- sync pulse on edge 20 → all strobes 0 after edge 20; next sys_clk_en 2 clk later, sam_clk_en 8 clk later, sym_clk_en 32 clk later. Repeat with sync on edge 32: the sym_clk_en strobe is suppressed.
- reset low for one edge mid-symbol (edge 13) → all outputs 0 the next cycle; timing restarts exactly as in the first scenario.
- SYS_DIV=1, SAM_DIV=1, SYM_DIV=3 → sys_clk_en and sam_clk_en high every cycle; sym_clk_en after edges 3,6,9.
- With CLK_EN_GEN_SAM2X_EN and defaults → sam2x_clk_en after edges 4,8,12,16…

Source files
------------

// File: rtl/clk_en_gen_if.sv
// Control and strobe bundle for clk_en_gen: the run/resync controls going in,
// the nested enable strobes and phase counters coming out.
interface clk_en_gen_if #(
  parameter int SAM_DIV = 4,
  parameter int SYM_DIV = 4
);
  localparam int SAM_W = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
  localparam int SYM_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  logic             en;
  logic             sync;
  logic             sys_clk_en;
  logic             sam_clk_en;
  logic             sym_clk_en;
  logic             sam2x_clk_en;
  logic [SAM_W-1:0] sam_phase;
  logic [SYM_W-1:0] sym_phase;

  modport master (
    output en, sync,
    input  sys_clk_en, sam_clk_en, sym_clk_en, sam2x_clk_en, sam_phase, sym_phase
  );

  modport slave (
    input  en, sync,
    output sys_clk_en, sam_clk_en, sym_clk_en, sam2x_clk_en, sam_phase, sym_phase
  );
endinterface

// File: rtl/clk_en_gen.sv
// Nested system/sample/symbol clock-enable generator with run/hold and phase resync.
// Optional half-sample strobe sam2x_clk_en is built only when CLK_EN_GEN_SAM2X_EN is defined.
module clk_en_gen #(
  parameter int SYS_DIV = 2,
  parameter int SAM_DIV = 4,
  parameter int SYM_DIV = 4
) (
  input logic        clk,
  input logic        reset,
  clk_en_gen_if.slave bus
);
  localparam int SYS_W = (SYS_DIV > 1) ? $clog2(SYS_DIV) : 1;
  localparam int SAM_W = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
  localparam int SYM_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  localparam logic [SYS_W-1:0] SYS_LAST = SYS_W'(SYS_DIV - 1);
  localparam logic [SAM_W-1:0] SAM_LAST = SAM_W'(SAM_DIV - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_DIV - 1);

  logic [SYS_W-1:0] r_sysCnt;
  logic [SAM_W-1:0] r_samCnt;
  logic [SYM_W-1:0] r_symCnt;
  logic             r_sysEn;
  logic             r_samEn;
  logic             r_symEn;

  logic             w_tS;
  logic             w_tA;
  logic             w_tY;
  logic [SYS_W-1:0] w_sysNext;
  logic [SAM_W-1:0] w_samNext;
  logic [SYM_W-1:0] w_symNext;

  // A DIV of 1 makes its counter stick at 0 with the terminal flag always true.
  always_comb begin
    w_tS      = (r_sysCnt == SYS_LAST);
    w_tA      = w_tS && (r_samCnt == SAM_LAST);
    w_tY      = w_tA && (r_symCnt == SYM_LAST);
    w_sysNext = w_tS ? '0 : r_sysCnt + SYS_W'(1);
    w_samNext = r_samCnt;
    w_symNext = r_symCnt;
    if (w_tS) w_samNext = w_tA ? '0 : r_samCnt + SAM_W'(1);
    if (w_tA) w_symNext = w_tY ? '0 : r_symCnt + SYM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sysCnt <= '0;
      r_samCnt <= '0;
      r_symCnt <= '0;
      r_sysEn  <= 1'b0;
      r_samEn  <= 1'b0;
      r_symEn  <= 1'b0;
    end else if (bus.sync) begin
      r_sysCnt <= '0;
      r_samCnt <= '0;
      r_symCnt <= '0;
      r_sysEn  <= 1'b0;
      r_samEn  <= 1'b0;
      r_symEn  <= 1'b0;
    end else if (!bus.en) begin
      r_sysEn  <= 1'b0;
      r_samEn  <= 1'b0;
      r_symEn  <= 1'b0;
    end else begin
      r_sysCnt <= w_sysNext;
      r_samCnt <= w_samNext;
      r_symCnt <= w_symNext;
      r_sysEn  <= w_tS;
      r_samEn  <= w_tA;
      r_symEn  <= w_tY;
    end
  end

  assign bus.sys_clk_en = r_sysEn;
  assign bus.sam_clk_en = r_samEn;
  assign bus.sym_clk_en = r_symEn;
  assign bus.sam_phase  = r_samCnt;
  assign bus.sym_phase  = r_symCnt;

`ifdef CLK_EN_GEN_SAM2X_EN
  localparam logic [SAM_W-1:0] SAM_HALF = SAM_W'(SAM_DIV / 2 - 1);

  if ((SAM_DIV < 2) || ((SAM_DIV % 2) != 0)) begin : g_badSam2x
    $error("clk_en_gen: half-sample strobe needs an even SAM_DIV of at least 2");
  end

  logic r_sam2xEn;

  // Second strobe lands mid-sample, so the pair is evenly spaced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sam2xEn <= 1'b0;
    end else if (bus.sync || !bus.en) begin
      r_sam2xEn <= 1'b0;
    end else begin
      r_sam2xEn <= w_tA || (w_tS && (r_samCnt == SAM_HALF));
    end
  end

  assign bus.sam2x_clk_en = r_sam2xEn;
`else
  assign bus.sam2x_clk_en = 1'b0;
`endif
endmodule
